shift_rows_pipe: RTL and testbench

- Parametrised, pipelined successor to the AES ShiftRows block.
- Supports Rijndael block widths Nb = 4, 6 or 8 columns, forward and inverse shift selected per beat, and a valid/ready stream handshake with backpressure.
- Sits between the SubBytes and MixColumns stages of the iterative round datapath of AES_Encryptor.
- Serves both the encrypt and decrypt paths.

---
 rtl/aes_pkg.sv | 23 ++
 rtl/shift_rows_perm.sv | 26 ++
 rtl/shift_rows_pipe.sv | 116 +++++++++++
 tb/tb_shift_rows_pipe.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// aes_pkg: shared AES state-width constants and the ShiftRows row-offset helper.
// The state vector type is parameterised per instance (state_t = logic [0:32*NB-1]
// declared inside each module), because a package cannot carry a parameter.
package aes_pkg;

    localparam int unsigned NB_128 = 32'd4;
    localparam int unsigned NB_192 = 32'd6;
    localparam int unsigned NB_256 = 32'd8;

    typedef logic [7:0] byte_t;

    // Rijndael row offset c_r: 0,1,2,3 for Nb=4/6 and 0,1,3,4 for Nb=8.
    function automatic int unsigned shift_ofs(input int unsigned nb, input int unsigned row);
        int unsigned ofs;
        if ((nb == NB_256) && (row >= 32'd2)) begin
            ofs = row + 32'd1;
        end else begin
            ofs = row;
        end
        return ofs;
    endfunction

endpackage

// File: rtl/shift_rows_perm.sv
// shift_rows_perm: purely combinational forward/inverse ShiftRows byte permutation.
// Byte (r,c) sits at bits [8*(r*NB+c) +: 8] of an ascending [0:W-1] vector, so
// byte 0 is the most significant byte.
module shift_rows_perm
    import aes_pkg::*;
#(
    parameter int NB = 4
)
(
    input  logic [0:32*NB-1] data,
    input  logic             inv,
    output logic [0:32*NB-1] perm
);

    // Each output byte is a mux between its forward and inverse source byte.
    for (genvar r = 0; r < 4; r++) begin : g_row
        for (genvar c = 0; c < NB; c++) begin : g_col
            localparam int OFS  = int'(shift_ofs(NB, r));
            localparam int FSRC = (c + OFS) % NB;
            localparam int ISRC = (c - OFS + NB) % NB;
            assign perm[8*(r*NB+c) +: 8] = inv ? data[8*(r*NB+ISRC) +: 8]
                                               : data[8*(r*NB+FSRC) +: 8];
        end
    end

endmodule

// File: rtl/shift_rows_pipe.sv
// shift_rows_pipe: pipelined ShiftRows/InvShiftRows with valid/ready handshake.
// Stage 0 captures the permuted input; later stages are plain delay registers.
// Empty stages never stall upstream (bubble collapse), and in_ready falls through
// combinationally from out_ready so a full pipeline keeps 1 beat/cycle.
// Optional build macro SHIFT_ROWS_PIPE_CNT_EN adds the beat_cnt output, a 16-bit
// wrapping count of completed output transfers that flush does not clear.
module shift_rows_pipe
    import aes_pkg::*;
#(
    parameter int NB          = 4,
    parameter int PIPE_STAGES = 1
)
(
    input  logic             clk,
    input  logic             n_rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [0:32*NB-1] in_data,
    input  logic             in_inv,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [0:32*NB-1] out_data
`ifdef SHIFT_ROWS_PIPE_CNT_EN
    ,
    output logic [15:0]      beat_cnt
`endif
);

    localparam int W = 32 * NB;
    typedef logic [0:W-1] state_t;

    state_t                 perm_s;
    state_t                 data_r      [PIPE_STAGES];
    state_t                 src_data_s  [PIPE_STAGES];
    logic [PIPE_STAGES-1:0] valid_r;
    logic [PIPE_STAGES-1:0] load_s;
    logic [PIPE_STAGES-1:0] src_valid_s;
    logic                   accept_s;
    logic                   out_xfer_s;

    shift_rows_perm #(
        .NB   (NB)
    ) u_perm (
        .data (in_data),
        .inv  (in_inv),
        .perm (perm_s)
    );

    // A stage may load when it or any stage downstream of it is empty, or out_ready frees the tail.
    always_comb begin : load_chain
        logic hole;
        hole   = out_ready;
        load_s = '0;
        for (int k = PIPE_STAGES - 1; k >= 0; k--) begin
            hole      = hole | ~valid_r[k];
            load_s[k] = hole;
        end
    end

    assign in_ready   = load_s[0] & ~flush;
    assign accept_s   = in_valid & in_ready;
    assign out_valid  = valid_r[PIPE_STAGES-1];
    assign out_data   = data_r[PIPE_STAGES-1];
    assign out_xfer_s = valid_r[PIPE_STAGES-1] & out_ready;

    // Source of each stage: the permuted input for stage 0, the previous stage otherwise.
    always_comb begin
        src_valid_s    = '0;
        src_data_s[0]  = perm_s;
        src_valid_s[0] = accept_s;
        for (int k = 1; k < PIPE_STAGES; k++) begin
            src_data_s[k]  = data_r[k-1];
            src_valid_s[k] = valid_r[k-1];
        end
    end

    // Pipeline registers: flush drops every beat but leaves data contents untouched.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            valid_r <= '0;
            for (int k = 0; k < PIPE_STAGES; k++) begin
                data_r[k] <= '0;
            end
        end else if (flush) begin
            valid_r <= '0;
        end else begin
            for (int k = 0; k < PIPE_STAGES; k++) begin
                if (load_s[k]) begin
                    valid_r[k] <= src_valid_s[k];
                    if (src_valid_s[k]) begin
                        data_r[k] <= src_data_s[k];
                    end
                end
            end
        end
    end

`ifdef SHIFT_ROWS_PIPE_CNT_EN
    logic [15:0] beat_cnt_r;

    // Completed output transfers, wrapping at 16 bits; survives flush.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            beat_cnt_r <= 16'd0;
        end else if (out_xfer_s) begin
            beat_cnt_r <= beat_cnt_r + 16'd1;
        end else begin
            beat_cnt_r <= beat_cnt_r;
        end
    end

    assign beat_cnt = beat_cnt_r;
`endif

endmodule

// File: tb/tb_shift_rows_pipe.sv
// tb_shift_rows_pipe: directed bench for shift_rows_pipe.
// Instance a: NB=4, 1 stage. Instance b: NB=8, 1 stage. Instance c: NB=4, 3 stages.
// Counter checks are compiled when SHIFT_ROWS_PIPE_CNT_EN is defined.
module tb_shift_rows_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic n_rst;
    logic flush;

    logic         a_in_valid, a_in_ready, a_in_inv, a_out_valid, a_out_ready;
    logic [0:127] a_in_data, a_out_data;
    logic         b_in_valid, b_in_ready, b_in_inv, b_out_valid, b_out_ready;
    logic [0:255] b_in_data, b_out_data;
    logic         c_in_valid, c_in_ready, c_in_inv, c_out_valid, c_out_ready;
    logic [0:127] c_in_data, c_out_data;
`ifdef SHIFT_ROWS_PIPE_CNT_EN
    logic [15:0]  a_cnt, b_cnt, c_cnt;
`endif

    int total = 0;
    int bad   = 0;

    shift_rows_pipe #(.NB(4), .PIPE_STAGES(1)) dut_a (
        .clk(clk), .n_rst(n_rst), .flush(flush),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data), .in_inv(a_in_inv),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data)
`ifdef SHIFT_ROWS_PIPE_CNT_EN
        , .beat_cnt(a_cnt)
`endif
    );

    shift_rows_pipe #(.NB(8), .PIPE_STAGES(1)) dut_b (
        .clk(clk), .n_rst(n_rst), .flush(flush),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_inv(b_in_inv),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data)
`ifdef SHIFT_ROWS_PIPE_CNT_EN
        , .beat_cnt(b_cnt)
`endif
    );

    shift_rows_pipe #(.NB(4), .PIPE_STAGES(3)) dut_c (
        .clk(clk), .n_rst(n_rst), .flush(flush),
        .in_valid(c_in_valid), .in_ready(c_in_ready), .in_data(c_in_data), .in_inv(c_in_inv),
        .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data)
`ifdef SHIFT_ROWS_PIPE_CNT_EN
        , .beat_cnt(c_cnt)
`endif
    );

    // Reference permutation written directly from the row-offset definition.
    function automatic logic [0:255] model(input int nb, input logic [0:255] d, input logic inv);
        logic [0:255] o;
        int ofs;
        int src;
        o = '0;
        for (int r = 0; r < 4; r++) begin
            ofs = (nb == 8 && r >= 2) ? r + 1 : r;
            for (int c = 0; c < nb; c++) begin
                src = inv ? (c - ofs + nb) % nb : (c + ofs) % nb;
                o[8*(r*nb+c) +: 8] = d[8*(r*nb+src) +: 8];
            end
        end
        return o;
    endfunction

    // One beat through instance a (out_ready held 1); returns what shows one cycle later.
    task automatic a_beat(input logic [0:127] d, input logic inv, output logic v, output logic [0:127] q);
        @(negedge clk);
        a_in_valid = 1'b1;
        a_in_data  = d;
        a_in_inv   = inv;
        @(negedge clk);
        a_in_valid = 1'b0;
        v = a_out_valid;
        q = a_out_data;
    endtask

    task automatic test_reset();
        n_rst = 1'b0;
        #12;
        total++; if (a_out_valid !== 1'b0) begin bad++; $display("FAIL reset_a_out_valid got %b exp 0", a_out_valid); end
        total++; if (a_out_data !== 128'h0) begin bad++; $display("FAIL reset_a_out_data got %h exp 0", a_out_data); end
        total++; if (a_in_ready !== 1'b1) begin bad++; $display("FAIL reset_a_in_ready got %b exp 1", a_in_ready); end
        total++; if (c_out_valid !== 1'b0 || c_out_data !== 128'h0) begin bad++; $display("FAIL reset_c_out got v=%b d=%h exp v=0 d=0", c_out_valid, c_out_data); end
        total++; if (b_out_data !== 256'h0) begin bad++; $display("FAIL reset_b_out_data got %h exp 0", b_out_data); end
        @(negedge clk);
        n_rst = 1'b1;
    endtask

    task automatic test_fwd_nb4();
        logic v;
        logic [0:127] q;
        a_beat(128'hd4e0b81e27bfb44111985d52aef1e530, 1'b0, v, q);
        total++; if (v !== 1'b1) begin bad++; $display("FAIL fwd_nb4_valid got %b exp 1", v); end
        total++; if (q !== 128'hd4e0b81ebfb441275d52119830aef1e5) begin bad++; $display("FAIL fwd_nb4_data got %h exp d4e0b81ebfb441275d52119830aef1e5", q); end
        @(negedge clk);
        total++; if (a_out_valid !== 1'b0) begin bad++; $display("FAIL fwd_nb4_single got out_valid %b exp 0", a_out_valid); end
    endtask

    task automatic test_inv_nb4();
        logic v;
        logic [0:127] q;
        a_beat(128'hd4e0b81ebfb441275d52119830aef1e5, 1'b1, v, q);
        total++; if (v !== 1'b1) begin bad++; $display("FAIL inv_nb4_valid got %b exp 1", v); end
        total++; if (q !== 128'hd4e0b81e27bfb44111985d52aef1e530) begin bad++; $display("FAIL inv_nb4_data got %h exp d4e0b81e27bfb44111985d52aef1e530", q); end
    endtask

    task automatic test_round_trip();
        logic v1, v2;
        logic [0:127] orig, mid, back;
        for (int i = 0; i < 1000; i++) begin
            orig = {$urandom, $urandom, $urandom, $urandom};
            a_beat(orig, 1'b0, v1, mid);
            a_beat(mid, 1'b1, v2, back);
            total++;
            if (v1 !== 1'b1 || v2 !== 1'b1 || back !== orig) begin
                bad++;
                $display("FAIL round_trip i=%0d got %h exp %h", i, back, orig);
            end
        end
    endtask

    task automatic test_nb8();
        logic [0:255] src;
        logic [0:255] exp_fwd;
        exp_fwd = 256'h0001020304050607090a0b0c0d0e0f0813141516171011121c1d1e1f18191a1b;
        for (int i = 0; i < 32; i++) begin
            src[8*i +: 8] = 8'(i);
        end
        @(negedge clk);
        b_in_valid = 1'b1; b_in_inv = 1'b0; b_in_data = src;
        @(negedge clk);
        b_in_valid = 1'b1; b_in_inv = 1'b1; b_in_data = exp_fwd;
        total++; if (b_out_valid !== 1'b1 || b_out_data !== exp_fwd) begin bad++; $display("FAIL nb8_fwd got v=%b %h exp %h", b_out_valid, b_out_data, exp_fwd); end
        total++; if (b_out_data[192:255] !== 64'h1c1d1e1f18191a1b) begin bad++; $display("FAIL nb8_row3 got %h exp 1c1d1e1f18191a1b", b_out_data[192:255]); end
        @(negedge clk);
        b_in_valid = 1'b0;
        total++; if (b_out_valid !== 1'b1 || b_out_data !== src) begin bad++; $display("FAIL nb8_inv got v=%b %h exp %h", b_out_valid, b_out_data, src); end
    endtask

    task automatic test_stream();
        logic [0:127] beats [10];
        logic [0:127] expq [$];
        logic [0:255] tmp;
        logic         prev_stall;
        logic [0:127] prev_data;
        logic         exp_rdy;
        int sent, recv, cyc;
        sent = 0; recv = 0; cyc = 0;
        prev_stall = 1'b0; prev_data = '0;
        for (int i = 0; i < 10; i++) begin
            beats[i] = {$urandom, $urandom, $urandom, $urandom};
        end
        while (recv < 10 && cyc < 300) begin
            @(negedge clk);
            c_out_ready = (cyc < 4) ? 1'b0 : 1'($urandom_range(0, 1));
            c_in_valid  = (sent < 10);
            c_in_data   = (sent < 10) ? beats[sent] : 128'h0;
            c_in_inv    = sent[0];
            #1;
            exp_rdy = !(expq.size() == 3 && !c_out_ready);
            total++;
            if (c_in_ready !== exp_rdy) begin bad++; $display("FAIL stream_in_ready cyc=%0d got %b exp %b", cyc, c_in_ready, exp_rdy); end
            if (prev_stall) begin
                total++;
                if (c_out_valid !== 1'b1 || c_out_data !== prev_data) begin bad++; $display("FAIL stream_stall_hold cyc=%0d got v=%b %h exp v=1 %h", cyc, c_out_valid, c_out_data, prev_data); end
            end
            if (c_out_valid && c_out_ready) begin
                total++;
                if (expq.size() == 0) begin
                    bad++; $display("FAIL stream_extra_beat cyc=%0d got %h exp none", cyc, c_out_data);
                end else begin
                    if (c_out_data !== expq[0]) begin bad++; $display("FAIL stream_data cyc=%0d got %h exp %h", cyc, c_out_data, expq[0]); end
                    void'(expq.pop_front());
                end
                recv++;
            end
            if (c_in_valid && c_in_ready) begin
                tmp = model(4, {c_in_data, 128'h0}, c_in_inv);
                expq.push_back(tmp[0:127]);
                sent++;
            end
            prev_stall = c_out_valid && !c_out_ready;
            prev_data  = c_out_data;
            cyc++;
        end
        total++; if (recv != 10) begin bad++; $display("FAIL stream_timeout got %0d beats exp 10", recv); end
        c_in_valid = 1'b0;
    endtask

    task automatic test_flush();
        logic [0:255] tmp;
        logic [0:127] d4;
        d4 = 128'h00112233445566778899aabbccddeeff;
        @(negedge clk);
        c_out_ready = 1'b0; c_in_valid = 1'b1; c_in_inv = 1'b0; c_in_data = 128'h1;
        @(negedge clk);
        c_in_data = 128'h2;
        @(negedge clk);
        c_in_valid = 1'b0;
        @(negedge clk);
        total++; if (c_out_valid !== 1'b1) begin bad++; $display("FAIL flush_pre_valid got %b exp 1", c_out_valid); end
        flush = 1'b1; c_in_valid = 1'b1; c_in_data = 128'h3;
        #1;
        total++; if (c_in_ready !== 1'b0) begin bad++; $display("FAIL flush_in_ready got %b exp 0", c_in_ready); end
        @(negedge clk);
        flush = 1'b0;
        total++; if (c_out_valid !== 1'b0) begin bad++; $display("FAIL flush_out_valid got %b exp 0", c_out_valid); end
        c_in_valid = 1'b1; c_in_inv = 1'b1; c_in_data = d4; c_out_ready = 1'b1;
        #1;
        total++; if (c_in_ready !== 1'b1) begin bad++; $display("FAIL flush_after_ready got %b exp 1", c_in_ready); end
        @(negedge clk);
        c_in_valid = 1'b0;
        total++; if (c_out_valid !== 1'b0) begin bad++; $display("FAIL flush_lat1 got %b exp 0", c_out_valid); end
        @(negedge clk);
        total++; if (c_out_valid !== 1'b0) begin bad++; $display("FAIL flush_lat2 got %b exp 0", c_out_valid); end
        @(negedge clk);
        tmp = model(4, {d4, 128'h0}, 1'b1);
        total++; if (c_out_valid !== 1'b1 || c_out_data !== tmp[0:127]) begin bad++; $display("FAIL flush_lat3 got v=%b %h exp v=1 %h", c_out_valid, c_out_data, tmp[0:127]); end
        @(negedge clk);
        total++; if (c_out_valid !== 1'b0) begin bad++; $display("FAIL flush_no_stale got %b exp 0", c_out_valid); end
    endtask

`ifdef SHIFT_ROWS_PIPE_CNT_EN
    task automatic test_beat_cnt();
        @(negedge clk);
        n_rst = 1'b0;
        #1;
        n_rst = 1'b1;
        total++; if (a_cnt !== 16'd0) begin bad++; $display("FAIL cnt_reset got %0d exp 0", a_cnt); end
        a_in_valid = 1'b1; a_in_inv = 1'b0; a_out_ready = 1'b1;
        for (int i = 0; i < 65537; i++) begin
            a_in_data = {4{i}};
            @(negedge clk);
        end
        a_in_valid = 1'b0;
        total++; if (a_cnt !== 16'd0) begin bad++; $display("FAIL cnt_wrap got %0d exp 0", a_cnt); end
        @(negedge clk);
        total++; if (a_cnt !== 16'd1) begin bad++; $display("FAIL cnt_after_wrap got %0d exp 1", a_cnt); end
        a_in_valid = 1'b1; a_in_data = 128'hffff;
        @(posedge clk);
        @(posedge clk);
        #2;
        total++; if (a_out_valid !== 1'b1 || a_cnt !== 16'd2) begin bad++; $display("FAIL cnt_pre_rst got v=%b cnt=%0d exp v=1 cnt=2", a_out_valid, a_cnt); end
        n_rst = 1'b0;
        #1;
        total++; if (a_out_valid !== 1'b0 || a_out_data !== 128'h0 || a_cnt !== 16'd0) begin bad++; $display("FAIL cnt_async_rst got v=%b d=%h cnt=%0d exp 0 0 0", a_out_valid, a_out_data, a_cnt); end
        @(negedge clk);
        a_in_valid = 1'b0;
        n_rst = 1'b1;
    endtask
`endif

    initial begin
        n_rst = 1'b0; flush = 1'b0;
        a_in_valid = 1'b0; a_in_inv = 1'b0; a_in_data = '0; a_out_ready = 1'b1;
        b_in_valid = 1'b0; b_in_inv = 1'b0; b_in_data = '0; b_out_ready = 1'b1;
        c_in_valid = 1'b0; c_in_inv = 1'b0; c_in_data = '0; c_out_ready = 1'b1;
        test_reset();
        test_fwd_nb4();
        test_inv_nb4();
        test_round_trip();
        test_nb8();
        test_stream();
        test_flush();
`ifdef SHIFT_ROWS_PIPE_CNT_EN
        test_beat_cnt();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
